// File: rtl/zeror_lsu_fsm.sv
// zeror_lsu_fsm: load/store unit bus controller. Issues one data-memory
// access at a time, drives byte enables and rotated store data, formats
// load results, and bounds the wait for read data with a timeout.
// Optional feature macro: ZEROR_LSU_MISALIGNED_EN. When defined, misaligned
// word/half accesses are split into two bus accesses; when undefined they are
// rejected with a single-cycle error pulse and never reach the bus.
module zeror_lsu_fsm #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // EX-stage request
    input  logic        data_req_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [31:0] adder_result_ex_i,
    input  logic [31:0] data_wdata_ex_i,
    // data-memory bus
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    // results and status
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_ready_ex_o,
    output logic        lsu_busy_o,
    output logic        lsu_err_o
);

    // Counter holds 0 .. BUS_TIMEOUT-1.
    localparam int CNT_W = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;

`ifdef ZEROR_LSU_MISALIGNED_EN
    typedef enum logic [2:0] {
        IDLE, WAIT_GNT, WAIT_RVALID, WAIT_GNT_MIS, WAIT_RVALID_MIS
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, WAIT_GNT, WAIT_RVALID
    } state_t;
`endif

    state_t state_q, state_d;

    // Access attributes captured while idle so the bus stays stable afterwards.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  type_q;
    logic        sign_q;
    logic        we_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Attributes of the access currently being handled: live EX inputs in
    // IDLE (zero-cycle issue), captured copies in every other state.
    logic        in_idle;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [1:0]  cur_type;
    logic [1:0]  cur_off;
    logic        cur_sign;
    logic        cur_we;
    logic        cur_misaligned;
    logic [3:0]  lane_base;
    logic        wait_rvalid;
    logic        timeout_hit;
    logic        reject;
    logic [31:0] rdata_low;
    logic [31:0] rd_rot;

    assign in_idle   = (state_q == IDLE);
    assign cur_addr  = in_idle ? adder_result_ex_i  : addr_q;
    assign cur_wdata = in_idle ? data_wdata_ex_i    : wdata_q;
    assign cur_type  = in_idle ? data_type_ex_i     : type_q;
    assign cur_sign  = in_idle ? data_sign_ext_ex_i : sign_q;
    assign cur_we    = in_idle ? data_we_ex_i       : we_q;
    assign cur_off   = cur_addr[1:0];

    // A word not on a word boundary, or a half whose second byte falls in the
    // next word, needs two bus accesses.
    assign cur_misaligned = ((cur_type == 2'b00) && (cur_off != 2'b00)) ||
                            ((cur_type == 2'b01) && (cur_off == 2'b11));

    // Lanes touched by the access when placed at offset 0.
    assign lane_base = (cur_type == 2'b00) ? 4'b1111 :
                       (cur_type == 2'b01) ? 4'b0011 : 4'b0001;

    assign timeout_hit = wait_rvalid && !data_rvalid_i &&
                         (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
    assign cnt_d       = (wait_rvalid && !data_rvalid_i && !timeout_hit) ?
                         cnt_q + 1'b1 : '0;

`ifdef ZEROR_LSU_MISALIGNED_EN
    logic [31:0] rdata_q;
    logic [7:0]  lanes_wide;
    logic        second_half;

    // Lanes past bit 3 belong to the following word (second access).
    assign lanes_wide  = {4'b0000, lane_base} << cur_off;
    assign wait_rvalid = (state_q == WAIT_RVALID) || (state_q == WAIT_RVALID_MIS);
    assign reject      = 1'b0;
    assign rdata_low   = (state_q == WAIT_RVALID_MIS) ? rdata_q : data_rdata_i;
    assign data_addr_o = second_half ? {addr_q[31:2] + 30'd1, 2'b00}
                                     : {cur_addr[31:2], 2'b00};
    assign data_be_o   = second_half ? lanes_wide[7:4] : lanes_wide[3:0];
`else
    assign wait_rvalid = (state_q == WAIT_RVALID);
    assign reject      = data_req_ex_i && cur_misaligned;
    assign rdata_low   = data_rdata_i;
    assign data_addr_o = {cur_addr[31:2], 2'b00};
    assign data_be_o   = lane_base << cur_off;
`endif

    assign data_we_o    = cur_we;
    assign lsu_busy_o   = !in_idle;
    // Store data rotated left by the byte offset (rotate right by 32-8*off).
    assign data_wdata_o = 32'({cur_wdata, cur_wdata} >> (6'd32 - {1'b0, cur_off, 3'b000}));
    // Load data rotated right by the byte offset; for a split load the
    // registered first word supplies the low half of the 64-bit window.
    assign rd_rot       = 32'({data_rdata_i, rdata_low} >> {cur_off, 3'b000});

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before the edge, independent of block order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture access attributes while idle, count response wait cycles, keep the first word of a split load.
    always_ff @(posedge clk) begin
        // NOTE: the captured attributes are reset along with the control state;
        // they are few flops and a clean reset keeps outputs defined after reset.
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef ZEROR_LSU_MISALIGNED_EN
            rdata_q <= '0;
`endif
        end else begin
            if (in_idle) begin
                addr_q  <= adder_result_ex_i;
                wdata_q <= data_wdata_ex_i;
                type_q  <= data_type_ex_i;
                sign_q  <= data_sign_ext_ex_i;
                we_q    <= data_we_ex_i;
            end
            cnt_q <= cnt_d;
`ifdef ZEROR_LSU_MISALIGNED_EN
            if ((state_q == WAIT_RVALID) && data_rvalid_i) begin
                rdata_q <= data_rdata_i;
            end
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_d unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_req_ex_i && !reject) begin
                    state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
`ifdef ZEROR_LSU_MISALIGNED_EN
                    state_d = cur_misaligned ? WAIT_GNT_MIS : IDLE;
`else
                    state_d = IDLE;
`endif
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
`ifdef ZEROR_LSU_MISALIGNED_EN
            WAIT_GNT_MIS: begin
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID_MIS;
                end
            end
            WAIT_RVALID_MIS: begin
                if (data_rvalid_i || timeout_hit) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Bus request, handshake to EX and error pulse per state.
    always_comb begin
        data_req_o     = 1'b0;
        lsu_ready_ex_o = 1'b0;
        lsu_err_o      = 1'b0;
`ifdef ZEROR_LSU_MISALIGNED_EN
        second_half    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!data_req_ex_i) begin
                    lsu_ready_ex_o = 1'b1;
                end else if (reject) begin
                    lsu_err_o      = 1'b1;
                    lsu_ready_ex_o = 1'b1;
                end else begin
                    data_req_o = 1'b1;
                end
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
`ifdef ZEROR_LSU_MISALIGNED_EN
                    lsu_ready_ex_o = !cur_misaligned;
`else
                    lsu_ready_ex_o = 1'b1;
`endif
                end else if (timeout_hit) begin
                    lsu_err_o      = 1'b1;
                    lsu_ready_ex_o = 1'b1;
                end
            end
`ifdef ZEROR_LSU_MISALIGNED_EN
            WAIT_GNT_MIS: begin
                data_req_o  = 1'b1;
                second_half = 1'b1;
            end
            WAIT_RVALID_MIS: begin
                second_half = 1'b1;
                if (data_rvalid_i) begin
                    lsu_ready_ex_o = 1'b1;
                end else if (timeout_hit) begin
                    lsu_err_o      = 1'b1;
                    lsu_ready_ex_o = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Extend the rotated load data to 32 bits by access size.
    always_comb begin
        case (cur_type)
            2'b00:   lsu_rdata_o = rd_rot;
            2'b01:   lsu_rdata_o = {{16{cur_sign & rd_rot[15]}}, rd_rot[15:0]};
            default: lsu_rdata_o = {{24{cur_sign & rd_rot[7]}}, rd_rot[7:0]};
        endcase
    end

endmodule
